// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, falling-edge start detect, mid-bit sampling,
// one-cycle o_valid / o_frame_err pulses.
module uart_rx #(
   parameter int CLK_FREQ  = 25_000_000,
   parameter int BAUD_RATE = 115_200
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_rx,
   output logic [7:0] o_data,
   output logic       o_valid,
   output logic       o_frame_err,
   output logic       o_busy
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
   localparam int CW           = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t          state, state_nxt;
   logic            rx_m, rx_s, rx_prev;
   logic [CW-1:0]   cnt;
   logic [2:0]      bit_idx;
   logic [7:0]      shift;
   logic            start_edge, cnt_last, cnt_half;

   assign start_edge = rx_prev & ~rx_s;
   assign cnt_last   = (cnt == CNT_LAST);
   assign cnt_half   = (cnt == CNT_HALF);
   assign o_busy     = (state != S_IDLE);

   always_ff @(posedge i_clk) begin
      if (i_reset) state <= S_IDLE;
      else         state <= state_nxt;
   end

   // A held-low line never re-triggers: leaving S_IDLE needs a 1->0 edge on rx_s.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start_edge) state_nxt = S_START;
         S_START: if (cnt_half)   state_nxt = rx_s ? S_IDLE : S_DATA;
         S_DATA:  if (cnt_last && bit_idx == 3'd7) state_nxt = S_STOP;
         S_STOP:  if (cnt_last)   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         rx_m        <= 1'b1;
         rx_s        <= 1'b1;
         rx_prev     <= 1'b1;
         cnt         <= '0;
         bit_idx     <= '0;
         shift       <= '0;
         o_data      <= '0;
         o_valid     <= 1'b0;
         o_frame_err <= 1'b0;
      end else begin
         rx_m        <= i_rx;
         rx_s        <= rx_m;
         rx_prev     <= rx_s;
         o_valid     <= 1'b0;
         o_frame_err <= 1'b0;

         // Counter restarts on any state change and at each bit boundary in S_DATA.
         if (state_nxt != state || cnt_last) cnt <= '0;
         else if (state != S_IDLE)           cnt <= cnt + 1'b1;

         if (state == S_IDLE) bit_idx <= '0;

         if (state == S_DATA && cnt_last) begin
            shift   <= {rx_s, shift[7:1]};
            bit_idx <= bit_idx + 1'b1;
         end

         if (state == S_STOP && cnt_last) begin
            if (rx_s) begin
               o_data  <= shift;
               o_valid <= 1'b1;
            end else begin
               o_frame_err <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a serial driver feeds frames, and an expectation queue
// (byte, good/bad stop, arrival cycle) is checked against the pulses every cycle.
module tb_uart_rx;

   localparam int CLK_FREQ = 5_000_000;
   localparam int BAUD     = 100_000;
   localparam int CPB      = CLK_FREQ / BAUD;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx;
   logic [7:0] data;
   logic       valid, ferr, busy;

   uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD)) dut (
      .i_clk(clk), .i_reset(rst), .i_rx(rx),
      .o_data(data), .o_valid(valid), .o_frame_err(ferr), .o_busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0] b;
      bit         good;
      int         t;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] exp_data = 8'h00;
   bit         gap_en = 1'b0;
   int         gap = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic wait_cyc(input int t);
      while (cyc < t) begin
         @(posedge clk);
         #1;
      end
   endtask

   // The line falls at c0; the stop bit mid-point is 9.5 bit times later and the
   // synchronizer plus edge detect add 3 clocks before the registered pulse.
   task automatic send_frame(input logic [7:0] b, input logic stop,
                             input int num, input int den, input bit expect_pulse);
      int         c0;
      logic [9:0] bits;
      exp_t       e;
      bits = {stop, b, 1'b0};
      @(posedge clk);
      #1;
      c0 = cyc;
      if (expect_pulse) begin
         e.b    = b;
         e.good = stop;
         e.t    = (num == den) ? c0 + (19 * CPB) / 2 + 3 : -1;
         exp_q.push_back(e);
      end
      for (int k = 0; k < 10; k++) begin
         wait_cyc(c0 + (k * CPB * den) / num);
         rx = bits[k];
      end
      wait_cyc(c0 + (10 * CPB * den) / num - 1);
   endtask

   always @(negedge clk) begin : compare
      exp_t e;
      if (rst) begin
         exp_data = 8'h00;
      end else begin
         if (valid && ferr) chk("pulse_exclusive", 1, 0);
         if (valid || ferr) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_pulse", {30'd0, valid, ferr}, 0);
            end else begin
               e = exp_q.pop_front();
               chk("pulse_kind_valid", valid, e.good);
               if (e.good) exp_data = e.b;
               if (e.t >= 0) chk("pulse_cycle", cyc, e.t);
            end
         end
         chk("data_hold", data, exp_data);
         if (gap_en) begin
            if (!busy) gap++;
            else begin
               if (gap > 0) chk("b2b_gap_short", gap <= CPB / 2 + 3, 1);
               gap = 0;
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int c0;
      rx  = 1'b1;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("reset_data", data, 0);
      chk("reset_valid", valid, 0);
      chk("reset_ferr", ferr, 0);
      chk("reset_busy", busy, 0);
      wait_cyc(cyc + CPB);

      // single frame
      send_frame(8'hA5, 1'b1, 1, 1, 1'b1);
      wait_cyc(cyc + CPB);
      chk("a5_literal", data, 8'hA5);

      // back-to-back, no idle gap
      gap    = 0;
      gap_en = 1'b1;
      send_frame(8'h00, 1'b1, 1, 1, 1'b1);
      send_frame(8'hFF, 1'b1, 1, 1, 1'b1);
      send_frame(8'h55, 1'b1, 1, 1, 1'b1);
      gap_en = 1'b0;
      wait_cyc(cyc + CPB);
      chk("b2b_last_literal", data, 8'h55);

      // short glitch rejected at the start sample
      @(posedge clk);
      #1;
      c0 = cyc;
      rx = 1'b0;
      wait_cyc(c0 + 5);
      chk("glitch_busy_high", busy, 1);
      wait_cyc(c0 + CPB / 4);
      rx = 1'b1;
      wait_cyc(c0 + CPB / 2 + 4);
      chk("glitch_busy_low", busy, 0);
      wait_cyc(cyc + CPB);
      send_frame(8'h3C, 1'b1, 1, 1, 1'b1);
      wait_cyc(cyc + CPB);
      chk("3c_literal", data, 8'h3C);

      // framing error followed by a break
      send_frame(8'h81, 1'b0, 1, 1, 1'b1);
      for (int i = 0; i < 20; i++) begin
         wait_cyc(cyc + CPB);
         chk("break_no_restart", busy, 0);
      end
      rx = 1'b1;
      wait_cyc(cyc + 2 * CPB);
      chk("ferr_data_kept", data, 8'h3C);
      send_frame(8'h5A, 1'b1, 1, 1, 1'b1);
      wait_cyc(cyc + CPB);
      chk("5a_literal", data, 8'h5A);

      // reset during data bit 3 of 0xF9 (line stays high from bit 3 on)
      @(posedge clk);
      #1;
      c0 = cyc;
      rx = 1'b0;
      wait_cyc(c0 + CPB);
      rx = 1'b1;
      wait_cyc(c0 + 2 * CPB);
      rx = 1'b0;
      wait_cyc(c0 + 4 * CPB);
      rx = 1'b1;
      wait_cyc(c0 + 4 * CPB + CPB / 2);
      chk("midframe_busy", busy, 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("mrst_data", data, 0);
      chk("mrst_valid", valid, 0);
      chk("mrst_ferr", ferr, 0);
      chk("mrst_busy", busy, 0);
      wait_cyc(cyc + 8 * CPB);
      send_frame(8'hC3, 1'b1, 1, 1, 1'b1);
      wait_cyc(cyc + CPB);
      chk("c3_literal", data, 8'hC3);

      // baud tolerance +2% / -2%
      send_frame(8'h6E, 1'b1, 102, 100, 1'b1);
      wait_cyc(cyc + CPB);
      chk("fast_6e_literal", data, 8'h6E);
      send_frame(8'h00, 1'b1, 1, 1, 1'b1);
      wait_cyc(cyc + CPB);
      send_frame(8'h6E, 1'b1, 98, 100, 1'b1);
      wait_cyc(cyc + 2 * CPB);
      chk("slow_6e_literal", data, 8'h6E);

      chk("all_frames_seen", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
